hazard_fwd_ctrl: RTL and testbench

- Central hazard and forwarding controller for the 4-stage integer pipeline (ID → EX → MEM → WB, 8 × 8-bit registers).
- Keeps its own shadow of register-usage metadata for the EX, MEM and WB stages, and compares it with the instruction in ID.
- Drives the `stall`/`flush` inputs of the IF/ID and ID/EX pipeline registers and the EX-stage operand-forwarding muxes.
- Counts stall and flush events for performance monitoring.

---
 rtl/hazard_fwd_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 4-stage integer pipeline: load-use stall,
// taken-branch flush, EX operand forwarding and saturating stall/flush counters.

// Per-operand forwarding select: the younger MEM producer wins over WB, but MEM
// loads have no result yet, and register 0 is never forwarded.
module hazard_fwd_sel #(
  parameter int RA_W = 3
) (
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_wr,
  input  logic            mem_ld,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_wr,
  output logic [1:0]      sel
);
  always_comb begin
    sel = 2'b00;
    if (mem_wr && !mem_ld && mem_rd != '0 && mem_rd == src)
      sel = 2'b01;
    else if (wb_wr && wb_rd != '0 && wb_rd == src)
      sel = 2'b10;
  end
endmodule

module hazard_fwd_ctrl #(
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_uses_rt,
  input  logic             id_wr,
  input  logic             id_ld,
  input  logic             branch_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_OPS = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            ld;
  } ex_sh_t;

  ex_sh_t          ex_q, ex_d;
  logic [RA_W-1:0] mem_rd, wb_rd;
  logic            mem_wr, mem_ld, wb_wr;
  logic            lu;

  always_comb begin
    lu = id_valid && ex_q.ld && ex_q.wr && ex_q.rd != '0 &&
         (ex_q.rd == id_rs || (id_uses_rt && ex_q.rd == id_rt));
    // A taken branch kills the would-be stalled instruction, so it never stalls.
    stall      = lu && !branch_taken;
    flush_ifid = branch_taken;
    flush_idex = lu || branch_taken;
    ex_d = '0;
    if (id_valid && !flush_idex)
      ex_d = '{rs: id_rs, rt: id_rt, rd: id_rd, wr: id_wr, ld: id_ld};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q   <= '0;
      mem_rd <= '0;
      mem_wr <= 1'b0;
      mem_ld <= 1'b0;
      wb_rd  <= '0;
      wb_wr  <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      mem_rd <= ex_q.rd;
      mem_wr <= ex_q.wr;
      mem_ld <= ex_q.ld;
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
    end
  end

  logic [NUM_OPS-1:0][RA_W-1:0] op_src;
  logic [NUM_OPS-1:0][1:0]      op_sel;

  assign op_src = {ex_q.rt, ex_q.rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd (
      .src    (op_src[g]),
      .mem_rd (mem_rd),
      .mem_wr (mem_wr),
      .mem_ld (mem_ld),
      .wb_rd  (wb_rd),
      .wb_wr  (wb_wr),
      .sel    (op_sel[g])
    );
  end

  assign fwd_a = op_sel[0];
  assign fwd_b = op_sel[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_taken && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: a driver advances an instruction-level
// pipeline model and queues expected outputs; a negedge monitor compares them.
module tb_hazard_fwd_ctrl;
  localparam int RA_W = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic id_valid = 1'b0, id_uses_rt = 1'b0, id_wr = 1'b0, id_ld = 1'b0;
  logic branch_taken = 1'b0;
  logic [RA_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;

  logic        stall, flush_ifid, flush_idex;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall4, flush_ifid4, flush_idex4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.RA_W(RA_W), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_wr(id_wr), .id_ld(id_ld),
    .branch_taken(branch_taken), .stall(stall), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_fwd_ctrl #(.RA_W(RA_W), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_wr(id_wr), .id_ld(id_ld),
    .branch_taken(branch_taken), .stall(stall4), .flush_ifid(flush_ifid4),
    .flush_idex(flush_idex4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  typedef struct {
    bit v; bit [2:0] rs, rt, rd; bit urt, wr, ld, bt;
  } stim_t;
  typedef struct {
    bit [2:0] rs, rt, rd; bit wr, ld;
  } instr_t;
  typedef struct {
    bit stall, fi, fx; bit [1:0] fa, fb; int sc, fc;
  } exp_t;

  exp_t   sb_q[$];
  instr_t pipe[3];             // 0 = EX, 1 = MEM, 2 = WB
  int     n_stall, n_flush;    // unsaturated event counts
  bit     e_stall, e_fx;
  bit     rst_next = 1'b0;
  int     n_cmp = 0, n_bad = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  // Select code = index of the stage holding the value: MEM (1) if it already has
  // a result, else the older WB (2), else the register file.
  function automatic bit [1:0] fwd_exp(bit [2:0] r);
    if (r == 0) return 2'd0;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].wr && pipe[s].rd == r && (s == 2 || !pipe[s].ld))
        return 2'(s);
    return 2'd0;
  endfunction

  function automatic void model_edge();
    instr_t nb;
    nb = '{default: 0};
    if (!rstn) begin
      for (int s = 0; s < 3; s++) pipe[s] = nb;
      n_stall = 0;
      n_flush = 0;
    end else begin
      n_stall += int'(e_stall);
      n_flush += int'(branch_taken);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (id_valid && !e_fx) pipe[0] = '{rs: id_rs, rt: id_rt, rd: id_rd, wr: id_wr, ld: id_ld};
      else pipe[0] = nb;
    end
  endfunction

  function automatic void calc_push();
    exp_t e;
    bit reads, lu;
    reads = (pipe[0].rd == id_rs) || (id_uses_rt && pipe[0].rd == id_rt);
    lu = id_valid && pipe[0].ld && pipe[0].wr && pipe[0].rd != 0 && reads;
    e_stall = lu && !branch_taken;
    e_fx = lu || branch_taken;
    e.stall = e_stall;
    e.fi = branch_taken;
    e.fx = e_fx;
    e.fa = fwd_exp(pipe[0].rs);
    e.fb = fwd_exp(pipe[0].rt);
    e.sc = n_stall;
    e.fc = n_flush;
    sb_q.push_back(e);
  endfunction

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    model_edge();
    rstn = rst_next;
    id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    id_uses_rt = s.urt; id_wr = s.wr; id_ld = s.ld; branch_taken = s.bt;
    calc_push();
  endtask

  function automatic stim_t alu(bit [2:0] rd, bit [2:0] rs, bit [2:0] rt, bit bt = 0);
    return '{v: 1, rs: rs, rt: rt, rd: rd, urt: 1, wr: 1, ld: 0, bt: bt};
  endfunction
  function automatic stim_t ldi(bit [2:0] rd, bit [2:0] rs);
    return '{v: 1, rs: rs, rt: 0, rd: rd, urt: 0, wr: 1, ld: 1, bt: 0};
  endfunction
  function automatic stim_t nop();
    return '{default: 0};
  endfunction

  // Monitor: compare whatever expectation the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stall", int'(stall), int'(e.stall));
        chk("flush_ifid", int'(flush_ifid), int'(e.fi));
        chk("flush_idex", int'(flush_idex), int'(e.fx));
        chk("fwd_a", int'(fwd_a), int'(e.fa));
        chk("fwd_b", int'(fwd_b), int'(e.fb));
        chk("stall_cnt", int'(stall_cnt), sat(e.sc, 65535));
        chk("flush_cnt", int'(flush_cnt), sat(e.fc, 65535));
        chk("stall4", int'(stall4), int'(e.stall));
        chk("fwd4", int'({fwd_a4, fwd_b4}), int'({e.fa, e.fb}));
        chk("stall_cnt4", int'(stall_cnt4), sat(e.sc, 15));
        chk("flush_cnt4", int'(flush_cnt4), sat(e.fc, 15));
      end
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    n_stall = 0; n_flush = 0; e_stall = 0; e_fx = 0;

    // Reset, with a branch toggled to see flush follow it during reset.
    step(nop());
    step(alu(0, 0, 0, 1));
    rst_next = 1'b1;
    step(nop());

    // Load-use: LD r3, then ADD rs=3 held in ID for the stall cycle.
    step(ldi(3, 1));
    step(alu(4, 3, 0));
    step(alu(4, 3, 0));
    step(nop());
    step(nop());

    // ALU chain: both operands from MEM.
    step(alu(2, 1, 1));
    step(alu(6, 2, 2));
    step(nop());
    step(nop());

    // Priority MEM over WB on rt, then the same with rd = 0.
    step(alu(5, 0, 0));
    step(alu(5, 0, 0));
    step(alu(6, 1, 5));
    step(nop());
    step(alu(0, 0, 0));
    step(alu(0, 0, 0));
    step(alu(6, 0, 0));
    step(nop());

    // Taken branch together with a load-use hazard.
    step(ldi(3, 0));
    step(alu(4, 3, 3, 1));
    step(nop());
    step(nop());

    // Back-to-back loads to the same rd, then a use.
    step(ldi(3, 0));
    step(ldi(3, 0));
    step(alu(4, 3, 0));
    step(alu(4, 3, 0));
    step(nop());
    step(nop());

    // Reset asserted in the middle of a stall cycle.
    step(ldi(3, 0));
    step(alu(4, 3, 0));
    @(negedge clk);
    #2;
    rstn = 1'b0;
    rst_next = 1'b0;
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    chk("rst_fwd", int'({fwd_a, fwd_b}), 0);
    chk("rst_flush_idex", int'(flush_idex), int'(branch_taken));
    step(nop());
    rst_next = 1'b1;
    step(alu(2, 1, 1));
    step(alu(3, 4, 5));
    step(nop());

    // 20 load-use stalls: the CNT_W=4 instance must stop at 15.
    step(ldi(1, 0));
    for (int i = 0; i < 20; i++) begin
      s = (i % 2 == 0) ? ldi(2, 1) : ldi(1, 2);
      step(s);
      step(s);
    end
    step(nop());

    // Random traffic with a small register pool for dense hazards.
    for (int i = 0; i < 600; i++) begin
      s.v   = ($urandom_range(0, 7) != 0);
      s.rs  = 3'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 7 : 3));
      s.rt  = 3'($urandom_range(0, 3));
      s.rd  = 3'($urandom_range(0, 3));
      s.urt = 1'($urandom_range(0, 1));
      s.wr  = ($urandom_range(0, 3) != 0);
      s.ld  = ($urandom_range(0, 2) == 0);
      s.bt  = ($urandom_range(0, 9) == 0);
      step(s);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) chk("scoreboard_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
